// File: rtl/wide_add_sequencer_if.sv
// Operand/result handshake plus the chunked port pair to the external ripple-carry adder.
interface wide_add_sequencer_if #(
    parameter int unsigned N = 16,
    parameter int unsigned K = 4
);
    localparam int unsigned W = N * K;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic [N-1:0] add_a;
    logic [N-1:0] add_b;
    logic         add_cin;
    logic [N-1:0] add_sum;
    logic         add_cout;

    modport slave (
        input  in_valid, a, b, cin, out_ready, add_sum, add_cout,
        output in_ready, out_valid, sum, cout, add_a, add_b, add_cin
    );

    modport master (
        output in_valid, a, b, cin, out_ready, add_sum, add_cout,
        input  in_ready, out_valid, sum, cout, add_a, add_b, add_cin
    );
endinterface

// File: rtl/wide_add_sequencer.sv
// W = N*K bit adder built by streaming one N-bit chunk per cycle through an
// external combinational adder, carrying between chunks in a register.
module wide_add_sequencer #(
    parameter int unsigned N = 16,
    parameter int unsigned K = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    wide_add_sequencer_if.slave bus
);
    localparam int unsigned W     = N * K;
    localparam int unsigned IDX_W = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [W-1:0]     sum_q;
    logic             cout_q;
    logic             carry_reg;
    logic [IDX_W-1:0] idx;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             accept;
    logic             last_chunk;

    // in_ready is registered, so nothing is accepted on the edge that releases reset
    assign accept     = (state == IDLE) && bus.in_valid && in_ready_q;
    assign last_chunk = (idx == IDX_W'(K - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last_chunk) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Adder drive: zero outside RUN so the adder sees quiet inputs while idle or in reset
    always_comb begin
        bus.add_a   = '0;
        bus.add_b   = '0;
        bus.add_cin = 1'b0;
        if (state == RUN) begin
            bus.add_a   = a_reg[int'(idx) * N +: N];
            bus.add_b   = b_reg[int'(idx) * N +: N];
            bus.add_cin = carry_reg;
        end
    end

    // Registered handshake flags follow the upcoming state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            in_ready_q  <= (state_nxt == IDLE);
            out_valid_q <= (state_nxt == DONE);
        end
    end

    // Operand capture and chunk-by-chunk sum assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            carry_reg <= 1'b0;
            idx       <= '0;
        end else begin
            if (accept) begin
                a_reg     <= bus.a;
                b_reg     <= bus.b;
                carry_reg <= bus.cin;
                idx       <= '0;
            end else if (state == RUN) begin
                sum_q[int'(idx) * N +: N] <= bus.add_sum;
                carry_reg                 <= bus.add_cout;
                if (last_chunk) begin
                    cout_q <= bus.add_cout;
                    idx    <= '0;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer with N=16, K=4 and a behavioural ripple-carry adder.
module tb_wide_add_sequencer;
    localparam int unsigned N = 16;
    localparam int unsigned K = 4;
    localparam int unsigned W = N * K;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    wide_add_sequencer_if #(.N(N), .K(K)) bus ();

    wide_add_sequencer #(.N(N), .K(K)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // External N-bit combinational adder
    assign {bus.add_cout, bus.add_sum} = (N+1)'(bus.add_a) + (N+1)'(bus.add_b) + (N+1)'(bus.add_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && bus.in_ready !== 1'b1; i++) tick();
        check("in_ready_wait", W'(bus.in_ready), W'(1));
    endtask

    // Accept operands, watch all K chunks, then optionally complete the handshake
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv, input logic [W-1:0] exp_sum, input logic exp_cout,
                          input logic [K-1:0] exp_cins, input bit handshake);
        logic [K-1:0] cins;
        logic         early_valid;
        wait_ready();
        bus.a        = av;
        bus.b        = bv;
        bus.cin      = cv;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        early_valid  = 1'b0;
        cins         = '0;
        for (int i = 0; i < int'(K); i++) begin
            cins[i]     = bus.add_cin;
            early_valid = early_valid | bus.out_valid;
            tick();
        end
        check({tag, "_early_valid"}, W'(early_valid), W'(0));
        check({tag, "_out_valid"}, W'(bus.out_valid), W'(1));
        check({tag, "_sum"}, bus.sum, exp_sum);
        check({tag, "_cout"}, W'(bus.cout), W'(exp_cout));
        check({tag, "_add_cin"}, W'(cins), W'(exp_cins));
        check({tag, "_in_ready_done"}, W'(bus.in_ready), W'(0));
        if (handshake) begin
            bus.out_ready = 1'b1;
            tick();
            bus.out_ready = 1'b0;
            check({tag, "_valid_drop"}, W'(bus.out_valid), W'(0));
            check({tag, "_in_ready_back"}, W'(bus.in_ready), W'(1));
        end
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;

        #3;
        check("rst_out_valid", W'(bus.out_valid), W'(0));
        check("rst_sum", bus.sum, W'(0));
        check("rst_add_a", W'(bus.add_a), W'(0));
        check("rst_add_cin", W'(bus.add_cin), W'(0));
        #20 rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", W'(bus.in_ready), W'(1));

        run_op("t1", 64'd10, 64'd5, 1'b0, 64'd15, 1'b0, 4'b0000, 1'b1);
        run_op("t2", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 4'b0010, 1'b1);
        run_op("t3", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 4'b1110, 1'b1);
        run_op("t4", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'b1111, 1'b1);

        // Backpressure with new operands pending
        run_op("t5", 64'd100, 64'd200, 1'b0, 64'd300, 1'b0, 4'b0000, 1'b0);
        bus.a        = 64'd3;
        bus.b        = 64'd4;
        bus.cin      = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_hold_valid", W'(bus.out_valid), W'(1));
            check("t5_hold_sum", bus.sum, 64'd300);
            check("t5_hold_cout", W'(bus.cout), W'(0));
            check("t5_hold_in_ready", W'(bus.in_ready), W'(0));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("t5_hs_valid", W'(bus.out_valid), W'(0));
        check("t5_hs_in_ready", W'(bus.in_ready), W'(1));
        tick();
        bus.in_valid = 1'b0;
        check("t5_accept_in_ready", W'(bus.in_ready), W'(0));
        for (int i = 0; i < int'(K) - 1; i++) tick();
        check("t5_pend_valid_early", W'(bus.out_valid), W'(0));
        tick();
        check("t5_pend_valid", W'(bus.out_valid), W'(1));
        check("t5_pend_sum", bus.sum, 64'd7);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;

        // Asynchronous reset in the middle of a RUN
        wait_ready();
        bus.a        = 64'd32767;
        bus.b        = 64'd1;
        bus.cin      = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", W'(bus.out_valid), W'(0));
        check("t6_rst_add_a", W'(bus.add_a), W'(0));
        check("t6_rst_sum", bus.sum, W'(0));
        #17 rst_n = 1'b1;
        tick();
        check("t6_post_in_ready", W'(bus.in_ready), W'(1));
        check("t6_post_valid", W'(bus.out_valid), W'(0));
        check("t6_post_sum", bus.sum, W'(0));
        check("t6_post_cout", W'(bus.cout), W'(0));
        run_op("t6b", 64'd255, 64'd1, 1'b0, 64'd256, 1'b0, 4'b0000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
